// File: rtl/axis_iter_div_pkg.sv
// Shared constants for the iterative divider: the default operand width,
// the FSM state encoding and the field positions inside m_axis_dout_tdata.
package axis_iter_div_pkg;

  localparam int unsigned DIV_W = 32;

  // Plain 2-bit constants so that legacy code can compare against them directly.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Result layout: {quotient, remainder}.
  localparam int unsigned QUO_HI = 2 * DIV_W - 1;
  localparam int unsigned QUO_LO = DIV_W;
  localparam int unsigned REM_HI = DIV_W - 1;
  localparam int unsigned REM_LO = 0;

endpackage

// File: rtl/axis_iter_div_if.sv
// Stream bundle between the ALU divide request logic and axis_iter_div.
//   s_axis_dividend_* : dividend operand channel (tdata/tvalid in, tready out)
//   s_axis_divisor_*  : divisor operand channel  (tdata/tvalid in, tready out)
//   m_axis_dout_*     : {quotient, remainder} result, tvalid is a one-cycle pulse
// Modports: slave = divider side, master = requester side.
interface axis_iter_div_if
  import axis_iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
);

  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_divisor_tdata,  s_axis_divisor_tvalid,
    output s_axis_dividend_tready, s_axis_divisor_tready,
    output m_axis_dout_tdata, m_axis_dout_tvalid
  );

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_divisor_tdata,  s_axis_divisor_tvalid,
    input  s_axis_dividend_tready, s_axis_divisor_tready,
    input  m_axis_dout_tdata, m_axis_dout_tvalid
  );

endinterface

// File: rtl/axis_iter_div_restore_step.sv
// One radix-2 restoring division step (combinational).
//   rem_i     : current partial remainder (WIDTH+1 bits)
//   dvd_bit_i : next dividend bit, MSB first
//   dsr_i     : divisor magnitude
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this step
module div_restore_step
  import axis_iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {2'b00, dsr_i};
    // Negative difference means the trial subtraction fails: keep the shifted value.
    q_o     = ~diff[WIDTH+1];
    rem_o   = q_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/axis_iter_div.sv
// Multi-cycle radix-2 restoring divider with AXI-stream-style operand channels.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : slave side of axis_iter_div_if (dividend, divisor, dout channels)
// Timeline for a handshake at edge T: RUN for WIDTH cycles, one FIX cycle for
// sign correction / divide-by-zero, one DONE cycle with tvalid high, then IDLE.
module axis_iter_div
  import axis_iter_div_pkg::*;
#(
  parameter int unsigned WIDTH  = DIV_W,
  parameter bit          SIGNED = 1'b1
) (
  input logic             clk,
  input logic             reset,
  axis_iter_div_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;

  logic [WIDTH:0]     step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   quo_fix, rem_base, rem_fix;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return (SIGNED && v[WIDTH-1]) ? -v : v;
  endfunction

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dsr_i     (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    tdata_d   = tdata_q;
    tvalid_d  = 1'b0;

    // A zero divisor magnitude only arises from a zero divisor.
    rem_base = (dsr_q == '0) ? dvd_q : rem_q[WIDTH-1:0];
    quo_fix  = (dsr_q == '0) ? '1 : (neg_quo_q ? -quo_q : quo_q);
    rem_fix  = neg_rem_q ? -rem_base : rem_base;

    case (state_q)
      ST_IDLE: begin
        if (bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid) begin
          dvd_d     = magnitude(bus.s_axis_dividend_tdata);
          dsr_d     = magnitude(bus.s_axis_divisor_tdata);
          quo_d     = '0;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = SIGNED && (bus.s_axis_dividend_tdata[WIDTH-1] ^
                                 bus.s_axis_divisor_tdata[WIDTH-1]);
          neg_rem_d = SIGNED && bus.s_axis_dividend_tdata[WIDTH-1];
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        // Rotate rather than shift: after WIDTH steps the dividend magnitude is
        // back in place and serves as the remainder for divide-by-zero.
        dvd_d = {dvd_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        tdata_d  = {quo_fix, rem_fix};
        tvalid_d = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
    end
  end

  assign bus.s_axis_dividend_tready = (state_q == ST_IDLE);
  assign bus.s_axis_divisor_tready  = (state_q == ST_IDLE);
  assign bus.m_axis_dout_tdata      = tdata_q;
  assign bus.m_axis_dout_tvalid     = tvalid_q;

endmodule

// File: tb/tb_axis_iter_div.sv
// Scoreboard bench for axis_iter_div: one signed and one unsigned instance.
module tb_axis_iter_div;
  import axis_iter_div_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_iter_div_if #(.WIDTH(DIV_W)) bus_u ();
  axis_iter_div_if #(.WIDTH(DIV_W)) bus_s ();

  axis_iter_div #(.WIDTH(DIV_W), .SIGNED(1'b0)) u_div_u (
    .clk(clk), .reset(reset), .bus(bus_u)
  );
  axis_iter_div #(.WIDTH(DIV_W), .SIGNED(1'b1)) u_div_s (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  typedef struct {
    logic [63:0] data;
    longint      due;
  } exp_t;

  exp_t        q_u[$];
  exp_t        q_s[$];
  logic [63:0] hold_u = '0;
  logic [63:0] hold_s = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc + 1, act, exp);
    end
  endtask

  // Truncating division from plain arithmetic on 64-bit integers.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    longint sa, sb, q, r;
    res = '0;
    if (b == 32'd0) begin
      res[QUO_HI:QUO_LO] = '1;
      res[REM_HI:REM_LO] = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      res[QUO_HI:QUO_LO] = q[31:0];
      res[REM_HI:REM_LO] = r[31:0];
    end else begin
      res[QUO_HI:QUO_LO] = a / b;
      res[REM_HI:REM_LO] = a % b;
    end
    return res;
  endfunction

  task automatic drive(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic va, input logic vb);
    if (sgn) begin
      bus_s.s_axis_dividend_tdata  = a;
      bus_s.s_axis_divisor_tdata   = b;
      bus_s.s_axis_dividend_tvalid = va;
      bus_s.s_axis_divisor_tvalid  = vb;
    end else begin
      bus_u.s_axis_dividend_tdata  = a;
      bus_u.s_axis_divisor_tdata   = b;
      bus_u.s_axis_dividend_tvalid = va;
      bus_u.s_axis_divisor_tvalid  = vb;
    end
  endtask

  function automatic logic ready(input bit sgn);
    return sgn ? bus_s.s_axis_dividend_tready : bus_u.s_axis_dividend_tready;
  endfunction

  // Presents one request; `pre` cycles with only the dividend valid come first.
  // Returns the handshake edge number and queues the expected result.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input int pre, input logic [63:0] exp_data, output longint t_hs);
    exp_t e;
    int   waited;
    if (pre > 0) begin
      drive(sgn, a, b, 1'b1, 1'b0);
      for (int i = 0; i < pre; i++) begin
        @(negedge clk);
        check("single_valid_no_accept", ready(sgn), 1);
      end
    end
    drive(sgn, a, b, 1'b1, 1'b1);
    waited = 0;
    while (!ready(sgn) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!ready(sgn)) begin
      check("accept_timeout", 0, 1);
      drive(sgn, a, b, 1'b0, 1'b0);
      t_hs = -1;
      return;
    end
    t_hs   = cyc + 1;
    e.data = exp_data;
    e.due  = t_hs + 34;
    if (sgn) q_s.push_back(e);
    else     q_u.push_back(e);
    @(posedge clk);
    #1;
    drive(sgn, a, b, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input bit sgn);
    int waited = 0;
    while (!ready(sgn) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("idle_timeout", ready(sgn), 1);
  endtask

  task automatic mon(input bit sgn);
    logic        v, rd, rs;
    logic [63:0] d;
    exp_t        e;
    longint      now;
    now = cyc + 1;
    v   = sgn ? bus_s.m_axis_dout_tvalid     : bus_u.m_axis_dout_tvalid;
    d   = sgn ? bus_s.m_axis_dout_tdata      : bus_u.m_axis_dout_tdata;
    rd  = sgn ? bus_s.s_axis_dividend_tready : bus_u.s_axis_dividend_tready;
    rs  = sgn ? bus_s.s_axis_divisor_tready  : bus_u.s_axis_divisor_tready;
    check("tready_pair", rs, rd);
    if (reset) begin
      check("reset_tvalid", v, 0);
      check("reset_tdata", d, 0);
      check("reset_tready", rd, 1);
      if (sgn) hold_s = '0;
      else     hold_u = '0;
      return;
    end
    if (sgn) begin
      while (q_s.size() > 0 && q_s[0].due < now) begin
        check("lost_tvalid", 0, 1);
        void'(q_s.pop_front());
      end
    end else begin
      while (q_u.size() > 0 && q_u[0].due < now) begin
        check("lost_tvalid", 0, 1);
        void'(q_u.pop_front());
      end
    end
    if (v) begin
      if ((sgn ? q_s.size() : q_u.size()) == 0) begin
        check("spurious_tvalid", 1, 0);
      end else begin
        e = sgn ? q_s.pop_front() : q_u.pop_front();
        check(sgn ? "result_s" : "result_u", d, e.data);
        check("latency", now, e.due);
      end
      if (sgn) hold_s = d;
      else     hold_u = d;
    end else begin
      check("hold_tdata", d, sgn ? hold_s : hold_u);
    end
  endtask

  always @(negedge clk) begin
    mon(1'b0);
    mon(1'b1);
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 8))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      6:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_run(input bit sgn, input int n);
    longint t, prev;
    logic [31:0] a, b;
    prev = -1;
    for (int i = 0; i < n; i++) begin
      a = pick();
      b = pick();
      issue(sgn, a, b, 0, ref_div(sgn, a, b), t);
      if (prev >= 0 && t >= 0) check("back_to_back_gap", 64'(t - prev), 35);
      prev = t;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t;
    int     waited;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, '0, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Unsigned 100 / 7 with tready profile across the whole operation.
    issue(1'b0, 32'd100, 32'd7, 0, {32'h0000_000E, 32'h0000_0002}, t);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      check("busy_tready", ready(1'b0), 0);
    end
    @(negedge clk);
    check("tready_after_done", ready(1'b0), 1);

    // Signed corner cases.
    issue(1'b1, 32'hFFFF_FFF9, 32'd2,         0, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, t);
    issue(1'b1, 32'd7,         32'hFFFF_FFFE, 0, {32'hFFFF_FFFD, 32'h0000_0001}, t);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, {32'h8000_0000, 32'h0000_0000}, t);
    issue(1'b1, 32'd5,         32'd0,         0, {32'hFFFF_FFFF, 32'h0000_0005}, t);
    issue(1'b1, 32'hFFFF_FFFB, 32'd0,         0, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, t);
    // Unsigned corner cases.
    issue(1'b0, 32'd5,         32'd0,         0, {32'hFFFF_FFFF, 32'h0000_0005}, t);
    issue(1'b0, 32'hFFFF_FFFF, 32'd0,         0, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, t);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, {32'h0000_0000, 32'h8000_0000}, t);

    // Dividend valid alone for 5 cycles before the divisor joins.
    wait_idle(1'b1);
    issue(1'b1, 32'd45, 32'd6, 5, {32'd7, 32'd3}, t);

    // Reset in the middle of RUN aborts the request without a result.
    wait_idle(1'b0);
    wait_idle(1'b1);
    issue(1'b1, 32'd1000, 32'd3, 0, ref_div(1'b1, 32'd1000, 32'd3), t);
    waited = 0;
    while (cyc + 1 < t + 10 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    #1 reset = 1'b1;
    void'(q_s.pop_back());
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b1, 32'd3, 32'd3, 0, {32'd1, 32'd0}, t);
    wait_idle(1'b1);

    // Randomized back-to-back traffic on both instances.
    fork
      rand_run(1'b0, 500);
      rand_run(1'b1, 500);
    join

    waited = 0;
    while ((q_u.size() + q_s.size()) != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 64'(q_u.size() + q_s.size()), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
